// File: rtl/csr_regfile_pkg.sv
// Shared CSR definitions: opcodes, addresses, writable-bit masks, reset values.
package csr_regfile_pkg;

  typedef enum logic [7:0] {
    OP_INVALID = 8'h00,
    OP_CSRRD   = 8'h01,
    OP_CSRWR   = 8'h02,
    OP_CSRXCHG = 8'h04
  } csr_op_e;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
  localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
  localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
  localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
  localparam logic [31:0] CRMD_RESET   = 32'h0000_0008;

  typedef enum logic {
    TMR_IDLE,
    TMR_COUNT
  } tmr_state_e;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (new_v & mask) | (old_v & ~mask);
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// WB-stage CSR access, exception/ertn commit and interrupt signals.
interface csr_regfile_if;
  logic [7:0]  csr_op;
  logic [13:0] csr_num;
  logic [31:0] csr_wdata;
  logic [31:0] csr_mask;
  logic [31:0] csr_rvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] era_out;
  logic        has_int;

  modport master (
    output csr_op, csr_num, csr_wdata, csr_mask, wb_ex, wb_ecode, wb_esubcode,
           wb_pc, ertn_flush, hw_int_in, ipi_int_in,
    input  csr_rvalue, ex_entry, era_out, has_int
  );

  modport slave (
    input  csr_op, csr_num, csr_wdata, csr_mask, wb_ex, wb_ecode, wb_esubcode,
           wb_pc, ertn_flush, hw_int_in, ipi_int_in,
    output csr_rvalue, ex_entry, era_out, has_int
  );
endinterface

// File: rtl/csr_timer.sv
// Stable timer: TVAL down-counter with periodic reload and 1->0 tick pulse.
module csr_timer
  import csr_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        load_en_i,
  input  logic [29:0] load_init_i,
  input  logic        periodic_i,
  input  logic [29:0] init_val_i,
  output logic [31:0] tval_o,
  output logic        tick_o
);

  tmr_state_e  state_q, state_d;
  logic [31:0] tval_q, tval_d;

  // State and counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TMR_IDLE;
      tval_q  <= '1;
    end else begin
      state_q <= state_d;
      tval_q  <= tval_d;
    end
  end

  // A TCFG write restarts the timer; a one-shot expiry parks TVAL at all-ones
  always_comb begin
    state_d = state_q;
    tval_d  = tval_q;
    tick_o  = 1'b0;
    if (load_i) begin
      tval_d  = {load_init_i, 2'b00};
      state_d = load_en_i ? TMR_COUNT : TMR_IDLE;
    end else if (state_q == TMR_COUNT) begin
      if (tval_q != '0) begin
        tval_d = tval_q - 32'd1;
        tick_o = (tval_q == 32'd1);
      end else if (periodic_i) begin
        tval_d = {init_val_i, 2'b00};
      end else begin
        tval_d  = '1;
        state_d = TMR_IDLE;
      end
    end
  end

  assign tval_o = tval_q;

endmodule

// File: rtl/csr_regfile.sv
// CSR register file and execution unit with exception/ertn handling.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input logic          clk,
  input logic          reset,
  csr_regfile_if.slave bus
);

  logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d;
  logic [31:0] estat_q, estat_d, era_q, era_d, eentry_q, eentry_d;
  logic [31:0] tid_q, tid_d, tcfg_q, tcfg_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];
  logic [31:0] old_val, new_val, tval;
  logic        we, ticlr, tcfg_we, tick;

  // Read mux: pre-write value of the addressed CSR
  always_comb begin
    case (bus.csr_num)
      CSR_CRMD:   old_val = crmd_q;
      CSR_PRMD:   old_val = prmd_q;
      CSR_ECFG:   old_val = ecfg_q;
      CSR_ESTAT:  old_val = estat_q;
      CSR_ERA:    old_val = era_q;
      CSR_EENTRY: old_val = eentry_q;
      CSR_SAVE0:  old_val = save_q[0];
      CSR_SAVE1:  old_val = save_q[1];
      CSR_SAVE2:  old_val = save_q[2];
      CSR_SAVE3:  old_val = save_q[3];
      CSR_TID:    old_val = tid_q;
      CSR_TCFG:   old_val = tcfg_q;
      CSR_TVAL:   old_val = tval;
      default:    old_val = '0;
    endcase
  end

  assign we      = (bus.csr_op == OP_CSRWR || bus.csr_op == OP_CSRXCHG)
                   && !bus.wb_ex && !bus.ertn_flush;
  assign new_val = (bus.csr_op == OP_CSRXCHG)
                   ? merge(old_val, bus.csr_wdata, bus.csr_mask) : bus.csr_wdata;
  assign ticlr   = we && (bus.csr_num == CSR_TICLR) && new_val[0];
  assign tcfg_we = we && (bus.csr_num == CSR_TCFG);

  csr_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .load_i      (tcfg_we),
    .load_en_i   (new_val[0]),
    .load_init_i (new_val[31:2]),
    .periodic_i  (tcfg_q[1]),
    .init_val_i  (tcfg_q[31:2]),
    .tval_o      (tval),
    .tick_o      (tick)
  );

  // Next state: software write, then exception/ertn override, then interrupt sampling
  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    ecfg_d   = ecfg_q;
    estat_d  = estat_q;
    era_d    = era_q;
    eentry_d = eentry_q;
    tid_d    = tid_q;
    tcfg_d   = tcfg_q;
    save_d   = save_q;
    if (we) begin
      case (bus.csr_num)
        CSR_CRMD:   crmd_d    = merge(crmd_q, new_val, CRMD_WMASK);
        CSR_PRMD:   prmd_d    = merge(prmd_q, new_val, PRMD_WMASK);
        CSR_ECFG:   ecfg_d    = merge(ecfg_q, new_val, ECFG_WMASK);
        CSR_ESTAT:  estat_d   = merge(estat_q, new_val, ESTAT_WMASK);
        CSR_ERA:    era_d     = new_val;
        CSR_EENTRY: eentry_d  = merge(eentry_q, new_val, EENTRY_WMASK);
        CSR_SAVE0:  save_d[0] = new_val;
        CSR_SAVE1:  save_d[1] = new_val;
        CSR_SAVE2:  save_d[2] = new_val;
        CSR_SAVE3:  save_d[3] = new_val;
        CSR_TID:    tid_d     = new_val;
        CSR_TCFG:   tcfg_d    = new_val;
        default:    ;
      endcase
    end
    if (bus.wb_ex) begin
      prmd_d[2:0]    = crmd_q[2:0];
      crmd_d[2:0]    = 3'b000;
      era_d          = bus.wb_pc;
      estat_d[21:16] = bus.wb_ecode;
      estat_d[30:22] = bus.wb_esubcode;
    end else if (bus.ertn_flush) begin
      crmd_d[2:0] = prmd_q[2:0];
    end
    estat_d[9:2] = bus.hw_int_in;
    estat_d[12]  = bus.ipi_int_in;
    estat_d[11]  = tick || (estat_q[11] && !ticlr);
  end

  // Architectural register update
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_q   <= CRMD_RESET;
      prmd_q   <= '0;
      ecfg_q   <= '0;
      estat_q  <= '0;
      era_q    <= '0;
      eentry_q <= '0;
      tid_q    <= TID_RESET;
      tcfg_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) save_q[i] <= '0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      estat_q  <= estat_d;
      era_q    <= era_d;
      eentry_q <= eentry_d;
      tid_q    <= tid_d;
      tcfg_q   <= tcfg_d;
      save_q   <= save_d;
    end
  end

  assign bus.csr_rvalue = (bus.csr_op == OP_INVALID) ? '0 : old_val;
  assign bus.ex_entry   = eentry_q;
  assign bus.era_out    = era_q;
  assign bus.has_int    = crmd_q[2] && |(estat_q[12:0] & ecfg_q[12:0]);

endmodule

// File: tb/tb_csr_regfile.sv
module tb_csr_regfile;
  import csr_regfile_pkg::*;

  localparam logic [31:0] TID_INIT = 32'hA5A5_0001;
  localparam int SEL_RV = 0, SEL_INT = 1, SEL_ERA = 2, SEL_ENTRY = 3;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;

  csr_regfile_if bus ();

  csr_regfile #(.TID_RESET(TID_INIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      SEL_RV:  return bus.csr_rvalue;
      SEL_INT: return {31'd0, bus.has_int};
      SEL_ERA: return bus.era_out;
      default: return bus.ex_entry;
    endcase
  endfunction

  // Monitor: pops expectations tagged with the current cycle
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: check missed, tagged cycle %0d seen at %0d", e.name, e.cyc, cyc);
      end else begin
        act = actual(e.sel);
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic chk(input int sel, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.csr_op     = OP_INVALID;
    bus.wb_ex      = 1'b0;
    bus.ertn_flush = 1'b0;
  endtask

  task automatic issue(input csr_op_e o, input logic [13:0] n,
                       input logic [31:0] wd, input logic [31:0] m);
    next_cycle();
    bus.csr_op    = o;
    bus.csr_num   = n;
    bus.csr_wdata = wd;
    bus.csr_mask  = m;
  endtask

  task automatic rd(input logic [13:0] n, input logic [31:0] v, input string name);
    issue(OP_CSRRD, n, 32'h0, 32'h0);
    chk(SEL_RV, v, name);
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] wd,
                    input logic [31:0] old_v, input string name);
    issue(OP_CSRWR, n, wd, 32'h0);
    chk(SEL_RV, old_v, name);
  endtask

  initial begin
    bus.csr_op = OP_INVALID; bus.csr_num = '0; bus.csr_wdata = '0; bus.csr_mask = '0;
    bus.wb_ex = 1'b0; bus.wb_ecode = '0; bus.wb_esubcode = '0; bus.wb_pc = '0;
    bus.ertn_flush = 1'b0; bus.hw_int_in = '0; bus.ipi_int_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    rd(CSR_CRMD, 32'h8, "crmd_rst");
    chk(SEL_INT, 32'h0, "has_int_rst");
    chk(SEL_ERA, 32'h0, "era_out_rst");
    chk(SEL_ENTRY, 32'h0, "ex_entry_rst");
    rd(CSR_TVAL, 32'hFFFF_FFFF, "tval_rst");
    rd(CSR_TID, TID_INIT, "tid_rst");
    wr(14'h007, 32'hFFFF_FFFF, 32'h0, "unmapped_wr");
    rd(14'h007, 32'h0, "unmapped_rd");
    issue(OP_INVALID, CSR_CRMD, 32'h0, 32'h0);
    chk(SEL_RV, 32'h0, "invalid_op_rd");

    wr(CSR_SAVE0, 32'hDEAD_BEEF, 32'h0, "save0_wr");
    issue(OP_CSRXCHG, CSR_SAVE0, 32'h0000_FFFF, 32'h0000_00FF);
    chk(SEL_RV, 32'hDEAD_BEEF, "save0_xchg_old");
    rd(CSR_SAVE0, 32'hDEAD_BEFF, "save0_xchg_new");
    wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h0, "ecfg_wr");
    rd(CSR_ECFG, 32'h0000_1BFF, "ecfg_mask");
    wr(CSR_ESTAT, 32'hFFFF_FFFF, 32'h0, "estat_wr");
    rd(CSR_ESTAT, 32'h0000_0003, "estat_sw_bits");
    wr(CSR_ESTAT, 32'h0, 32'h3, "estat_clr");
    rd(CSR_ESTAT, 32'h0, "estat_zero");

    next_cycle();
    bus.hw_int_in = 8'h81; bus.ipi_int_in = 1'b1;
    rd(CSR_ESTAT, 32'h0000_1204, "is_hw_ipi");
    chk(SEL_INT, 32'h0, "has_int_ie0");
    bus.hw_int_in = 8'h00; bus.ipi_int_in = 1'b0;
    rd(CSR_ESTAT, 32'h0, "is_hw_drop");

    wr(CSR_CRMD, 32'h7, 32'h8, "crmd_wr");
    rd(CSR_CRMD, 32'h7, "crmd_rd");
    issue(OP_CSRWR, CSR_ERA, 32'h1234, 32'h0);
    bus.wb_ex = 1'b1; bus.wb_ecode = 6'h0B; bus.wb_esubcode = 9'h005; bus.wb_pc = 32'h1C00_0100;
    chk(SEL_RV, 32'h0, "era_old_at_ex");
    rd(CSR_CRMD, 32'h0, "crmd_after_ex");
    chk(SEL_ERA, 32'h1C00_0100, "era_out_ex");
    rd(CSR_PRMD, 32'h7, "prmd_after_ex");
    rd(CSR_ESTAT, 32'h014B_0000, "estat_ecode");
    rd(CSR_ERA, 32'h1C00_0100, "era_wr_dropped");
    issue(OP_CSRWR, CSR_SAVE1, 32'h55, 32'h0);
    bus.ertn_flush = 1'b1;
    chk(SEL_RV, 32'h0, "save1_old_at_ertn");
    rd(CSR_CRMD, 32'h7, "crmd_after_ertn");
    rd(CSR_SAVE1, 32'h0, "save1_wr_dropped");
    wr(CSR_EENTRY, 32'hFFFF_FFFF, 32'h0, "eentry_wr");
    rd(CSR_EENTRY, 32'hFFFF_FFC0, "eentry_rd");
    chk(SEL_ENTRY, 32'hFFFF_FFC0, "ex_entry_out");

    wr(CSR_TCFG, 32'h13, 32'h0, "tcfg_periodic");
    for (int k = 1; k <= 17; k++) begin
      rd(CSR_TVAL, 32'(17 - k), "tval_count");
      if (k >= 16) chk(SEL_INT, (k == 17) ? 32'h1 : 32'h0, "has_int_timer");
    end
    rd(CSR_TVAL, 32'd16, "tval_reload");
    rd(CSR_TVAL, 32'd15, "tval_after_reload");
    rd(CSR_ESTAT, 32'h014B_0800, "is11_set");
    wr(CSR_TICLR, 32'h1, 32'h0, "ticlr_reads0");
    rd(CSR_ESTAT, 32'h014B_0000, "is11_cleared");
    chk(SEL_INT, 32'h0, "has_int_cleared");

    wr(CSR_TCFG, 32'h5, 32'h13, "tcfg_oneshot");
    rd(CSR_TVAL, 32'd4, "os_tval4");
    rd(CSR_TVAL, 32'd3, "os_tval3");
    rd(CSR_TVAL, 32'd2, "os_tval2");
    wr(CSR_TICLR, 32'h1, 32'h0, "ticlr_tie");
    chk(SEL_INT, 32'h0, "has_int_pre_tie");
    rd(CSR_TVAL, 32'd0, "os_tval0");
    chk(SEL_INT, 32'h1, "tie_set_wins");
    for (int k = 0; k < 3; k++) rd(CSR_TVAL, 32'hFFFF_FFFF, "os_stopped");

    wr(CSR_TCFG, 32'h13, 32'h5, "tcfg_restart");
    rd(CSR_TVAL, 32'd16, "mid_tval16");
    rd(CSR_TVAL, 32'd15, "mid_tval15");
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    rd(CSR_TCFG, 32'h0, "tcfg_after_rst");
    rd(CSR_TVAL, 32'hFFFF_FFFF, "tval_after_rst");
    rd(CSR_ESTAT, 32'h0, "estat_after_rst");
    chk(SEL_INT, 32'h0, "has_int_after_rst");
    rd(CSR_CRMD, 32'h8, "crmd_after_rst");
    rd(CSR_TVAL, 32'hFFFF_FFFF, "tval_idle_hold");
    rd(CSR_SAVE0, 32'h0, "save0_after_rst");

    next_cycle();
    next_cycle();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Control-status register file and CSR execution unit for the LoongArch pipeline.
- Consumes the 8-bit CSR op produced by the ID-stage CSR decoder (OP_CSRRD / OP_CSRWR / OP_CSRXCHG / OP_INVALID) once the instruction reaches WB.
- Performs the read or masked write, and handles exception entry and ertn return.
- Runs the stable timer and generates the interrupt-pending flag for the front end.

Parameters:
- TID_RESET, 32'h0, reset value of the TID register.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- csr_op  input  8  CSR opcode from the decoder path (OP_* codes in defs.v); valid-qualified upstream, so OP_INVALID means no access.
- csr_num  input  14  CSR address (inst[23:10]).
- csr_wdata  input  32  rd value, used by csrwr/csrxchg.
- csr_mask  input  32  rj value, the write mask for csrxchg.
- csr_rvalue  output  32  old value of the addressed CSR (combinational).
- wb_ex  input  1  exception commits this cycle.
- wb_ecode  input  6  exception code.
- wb_esubcode  input  9  exception subcode.
- wb_pc  input  32  PC of the excepting instruction.
- ertn_flush  input  1  ertn commits this cycle.
- hw_int_in  input  8  external hardware interrupt lines.
- ipi_int_in  input  1  inter-processor interrupt.
- ex_entry  output  32  EENTRY value, the exception target.
- era_out  output  32  ERA value, the ertn target.
- has_int  output  1  an enabled interrupt is pending.

Behaviour:
- Register map (csr_num):
  - CRMD 0x0: PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5], DATM[8:7].
  - PRMD 0x1: PPLV[1:0], PIE[2].
  - ECFG 0x4: LIE[12:0], bit 10 reserved.
  - ESTAT 0x5: IS[12:0], Ecode[21:16], EsubCode[30:22].
  - ERA 0x6, EENTRY 0xC (VA[31:6]).
  - SAVE0-3 0x30-0x33.
  - TID 0x40.
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
  - TVAL 0x42, read-only.
  - TICLR 0x44: CLR[0], write-1 action, reads 0.
- Unmapped addresses read 0; writes to them are ignored. Reserved bits read 0 and are never written.
- Reset values:
  - CRMD = 32'h8 (DA=1).
  - TID = TID_RESET.
  - TCFG.En = 0; TVAL = 32'hFFFF_FFFF.
  - All other CSRs, ESTAT.IS and ESTAT.Ecode = 0.
  - Outputs follow from these: has_int = 0, ex_entry = 0, era_out = 0.
- Read: csr_rvalue is combinational from the current state, with zero latency, for any op other than OP_INVALID. For OP_INVALID it is 0.
- Write: takes effect at the next edge. Only software-writable bits change:
  - OP_CSRWR: new = csr_wdata.
  - OP_CSRXCHG: new = (csr_wdata & csr_mask) | (old & ~csr_mask).
  - OP_CSRRD: no write.
- csrwr/csrxchg return the pre-write value in csr_rvalue.
- Software-writable ESTAT bits are IS[1:0] only.
- Writing TCFG also loads TVAL <= {new InitVal, 2'b00} at the same edge.
- Exception entry (wb_ex=1):
  - PRMD.PPLV <= CRMD.PLV; PRMD.PIE <= CRMD.IE.
  - CRMD.PLV <= 0; CRMD.IE <= 0.
  - ERA <= wb_pc; ESTAT.Ecode <= wb_ecode; ESTAT.EsubCode <= wb_esubcode.
- ertn (ertn_flush=1): CRMD.PLV <= PRMD.PPLV; CRMD.IE <= PRMD.PIE.
- Priority in one cycle: wb_ex > ertn_flush > CSR write.
  - A write is suppressed when wb_ex or ertn_flush is high.
  - Interrupt sampling and the timer run regardless.
- Interrupt status, every cycle:
  - IS[9:2] <= hw_int_in.
  - IS[12] <= ipi_int_in.
  - IS[11] is the sticky timer flag.
- Timer state machine (IDLE / COUNT), sub-module csr_timer:
  - IDLE while En=0: TVAL holds its value.
  - COUNT while En=1 and TVAL!=0: TVAL decrements by 1 each cycle.
  - On the edge where TVAL goes 1 -> 0, IS[11] is set.
  - TVAL==0 with En=1 and Periodic=1: reload {InitVal, 2'b00} the next cycle.
  - TVAL==0 with Periodic=0: TVAL <= 32'hFFFF_FFFF and the timer stops (back to IDLE).
  - Writing TICLR with bit 0 = 1 clears IS[11]. If the timer sets IS[11] in the same cycle, the set wins.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).
- A synchronous reset mid-count overrides everything; the timer returns to IDLE.

Decomposition:
- defs.v (shared): CSR address constants, field bit positions, writable-bit masks per CSR, CRMD reset value. The OP_CSR* codes already live there.
- Sub-module csr_timer: TVAL counter, reload, timer-interrupt set pulse.
- csr_regfile: instantiates csr_timer and holds the register state, write muxing and interrupt logic.

Test Plan:
- Reset, then csrrd CRMD -> csr_rvalue = 32'h8; has_int = 0; TVAL = 32'hFFFF_FFFF.
- csrwr SAVE0 = 32'hDEAD_BEEF, then csrxchg SAVE0 with wdata 32'h0000_FFFF, mask 32'h0000_00FF -> rvalue = 32'hDEAD_BEEF; next read = 32'hDEAD_BEFF.
- CRMD = 32'h7 (PLV=3, IE=1); wb_ex with ecode 6'h0B, pc 32'h1C00_0100 -> CRMD = 0, PRMD = 3'b111, ERA = 32'h1C00_0100, Ecode = 0xB; then ertn -> CRMD[2:0] = 3'b111.
- Same-cycle csrwr ERA = 32'h1234 and wb_ex -> ERA = wb_pc; the write is dropped.
- TCFG = 32'h0000_0013 (InitVal=4, periodic, en): TVAL counts 16 -> 0, IS[11] is set on the 1 -> 0 edge, then TVAL reloads 16. With LIE[11] = 1 and IE = 1, has_int = 1. A TICLR write of 1 clears IS[11].
- TCFG one-shot, InitVal=1 -> TVAL = 4..0, then 32'hFFFF_FFFF and stays there. Reset asserted mid-count -> TCFG.En = 0 and IS[11] = 0.
